// File: rtl/dmem_cache.sv
//----------------------------------------------------------------------------
// dmem_cache : direct-mapped, write-back, write-allocate L1 data cache (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module dmem_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic [31:0]  write_data,
  input  logic [3:0]   mem_read,
  input  logic [2:0]   mem_write,
  output logic [31:0]  read_data,
  output logic         busywait,
  output logic         main_read,
  output logic         main_write,
  output logic [27:0]  main_addr,
  output logic [127:0] main_writedata,
  input  logic [127:0] main_readdata,
  input  logic         main_busywait
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [127:0]         lines [NUM_LINES];
  logic [127:0]         fill;
  logic [27:0]          miss_blk;
  logic [31:0]          last_rd;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic             is_store;
  logic             is_load;
  logic             access;
  logic             hit;
  logic [127:0]     line;
  logic [31:0]      word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic [127:0]     merged;

  assign idx      = addr[4 +: IDX_W];
  assign tag      = addr[31 -: TAG_W];
  assign fill_idx = miss_blk[IDX_W-1:0];
  // A simultaneous load and store is treated as the store alone.
  assign is_store = mem_write[2];
  assign is_load  = mem_read[3] & ~is_store;
  assign access   = mem_read[3] | is_store;
  assign hit      = valid[idx] && (tags[idx] == tag);

  assign line   = lines[idx];
  assign word   = line[{addr[3:2], 5'b0} +: 32];
  assign byte_v = word[{addr[1:0], 3'b0} +: 8];
  assign half_v = word[{addr[1], 4'b0} +: 16];

  assign busywait  = (state != IDLE) || (access && !hit);
  assign read_data = (is_load && hit && state == IDLE) ? load_val : last_rd;

  always_comb begin
    load_val = word;
    case (mem_read[2:0])
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'b0, byte_v};
      3'b101:  load_val = {16'b0, half_v};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = line;
    case (mem_write[1:0])
      2'b00:   merged[{addr[3:0], 3'b0} +: 8]  = write_data[7:0];
      2'b01:   merged[{addr[3:1], 4'b0} +: 16] = write_data[15:0];
      default: merged[{addr[3:2], 5'b0} +: 32] = write_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      dirty          <= '0;
      main_read      <= 1'b0;
      main_write     <= 1'b0;
      main_addr      <= '0;
      main_writedata <= '0;
      last_rd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (hit) begin
              if (is_store) begin
                lines[idx] <= merged;
                dirty[idx] <= 1'b1;
              end else begin
                last_rd <= load_val;
              end
            end else if (valid[idx] && dirty[idx]) begin
              state          <= WRITEBACK;
              main_write     <= 1'b1;
              main_addr      <= {tags[idx], idx};
              main_writedata <= line;
              miss_blk       <= addr[31:4];
            end else begin
              state     <= FETCH;
              main_read <= 1'b1;
              main_addr <= addr[31:4];
              miss_blk  <= addr[31:4];
            end
          end
        end
        WRITEBACK: begin
          // The miss address is latched so the refill survives the CPU dropping the access.
          if (!main_busywait) begin
            state      <= FETCH;
            main_write <= 1'b0;
            main_read  <= 1'b1;
            main_addr  <= miss_blk;
          end
        end
        FETCH: begin
          if (!main_busywait) begin
            state     <= UPDATE;
            main_read <= 1'b0;
            fill      <= main_readdata;
          end
        end
        UPDATE: begin
          state           <= IDLE;
          lines[fill_idx] <= fill;
          tags[fill_idx]  <= miss_blk[27 -: TAG_W];
          valid[fill_idx] <= 1'b1;
          dirty[fill_idx] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_cache.sv
//----------------------------------------------------------------------------
// tb_dmem_cache : scoreboard bench for dmem_cache against a flat byte-memory model (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [31:0]  write_data;
  logic [3:0]   mem_read;
  logic [2:0]   mem_write;
  logic [31:0]  read_data;
  logic         busywait;
  logic         main_read;
  logic         main_write;
  logic [27:0]  main_addr;
  logic [127:0] main_writedata;
  logic [127:0] main_readdata;
  logic         main_busywait;

  dmem_cache #(.NUM_LINES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .write_data     (write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .read_data      (read_data),
    .busywait       (busywait),
    .main_read      (main_read),
    .main_write     (main_write),
    .main_addr      (main_addr),
    .main_writedata (main_writedata),
    .main_readdata  (main_readdata),
    .main_busywait  (main_busywait)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // CPU-visible memory as a flat byte array; the cache must be transparent to it.
  logic [7:0]   init_mem [4096];
  logic [7:0]   ref_mem  [4096];
  logic [31:0]  exp_q [$];

  // Backing main memory with a per-request latency.
  logic [127:0] bmem [256];
  logic [127:0] tmp_blk;
  bit           mem_loaded = 1'b0;
  int           mcnt = 0;
  int           mlat = 3;
  int           fixed_lat = 3;

  assign main_busywait = (main_read || main_write) && (mcnt < mlat);
  assign main_readdata = bmem[main_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) begin
        for (int k = 0; k < 16; k++) tmp_blk[k*8 +: 8] = init_mem[i*16 + k];
        bmem[i] <= tmp_blk;
      end
      mem_loaded <= 1'b1;
    end else if ((main_read || main_write) && mcnt < mlat) begin
      mcnt <= mcnt + 1;
    end else begin
      if (main_write) bmem[main_addr[7:0]] <= main_writedata;
      mcnt <= 0;
      mlat <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
  end

  // Bus probe and scoreboard monitor.
  bit          wb_seen, rd_seen;
  logic [27:0] wb_addr, rd_addr;
  logic [31:0] wb_word0;
  int          traffic = 0;
  logic [31:0] exp_v;

  always @(negedge clk) begin
    if (!rst) begin
      if (main_read || main_write) begin
        traffic++;
        vectors++;
        if (main_read && main_write) begin
          miscompares++;
          $display("FAIL bus_exclusive: main_read=%b main_write=%b, required not both high", main_read, main_write);
        end
        if (main_write) begin
          wb_seen = 1'b1; wb_addr = main_addr; wb_word0 = main_writedata[31:0];
        end
        if (main_read) begin
          rd_seen = 1'b1; rd_addr = main_addr;
        end
      end
      if (mem_read[3] && !mem_write[2] && !busywait) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL load_unexpected: read_data=%h with no expected load", read_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (read_data !== exp_v) begin
            miscompares++;
            $display("FAIL load_data addr=%h f3=%b: got %h required %h", addr, mem_read[2:0], read_data, exp_v);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
    logic [11:0] wa;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    wa = {a[11:2], 2'b00};
    w  = {ref_mem[wa + 12'd3], ref_mem[wa + 12'd2], ref_mem[wa + 12'd1], ref_mem[wa]};
    b  = ref_mem[a[11:0]];
    h  = {ref_mem[{a[11:2], a[1], 1'b1}], ref_mem[{a[11:2], a[1], 1'b0}]};
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic [11:0] wa;
    wa = {a[11:2], 2'b00};
    case (f)
      2'b00: ref_mem[a[11:0]] = wd[7:0];
      2'b01: begin
        ref_mem[{a[11:2], a[1], 1'b0}] = wd[7:0];
        ref_mem[{a[11:2], a[1], 1'b1}] = wd[15:8];
      end
      default: for (int k = 0; k < 4; k++) ref_mem[wa + 12'(k)] = wd[k*8 +: 8];
    endcase
  endtask

  task automatic do_access(input bit st, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, output int stalls);
    @(posedge clk); #1;
    addr = a; write_data = wd;
    if (st) begin
      mem_write = {1'b1, f[1:0]}; mem_read = 4'b0;
      ref_store(f[1:0], a, wd);
    end else begin
      mem_read = {1'b1, f}; mem_write = 3'b0;
      exp_q.push_back(ref_load(f, a));
    end
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!busywait) break;
      stalls++;
      if (stalls > 200) begin
        miscompares++;
        $display("FAIL access_timeout addr=%h: busywait stuck high", a);
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 4'b0; mem_write = 3'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  initial begin
    int st, t0, wait_cnt;
    logic [2:0] lf [5];
    lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;

    for (int a = 0; a < 4096; a++) init_mem[a] = 8'((a * 37) + (a >> 8) * 11 + 5);
    {init_mem[32'h43], init_mem[32'h42], init_mem[32'h41], init_mem[32'h40]} = 32'hDEADBEEF;
    for (int a = 0; a < 4096; a++) ref_mem[a] = init_mem[a];

    rst = 1'b1; addr = '0; write_data = '0; mem_read = '0; mem_write = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst busywait",       32'(busywait),       32'd0);
    check("rst main_read",      32'(main_read),      32'd0);
    check("rst main_write",     32'(main_write),     32'd0);
    check("rst main_addr",      32'(main_addr),      32'd0);
    check("rst main_writedata", 32'(|main_writedata), 32'd0);
    check("rst read_data",      read_data,           32'd0);

    // Cold load: 1 miss cycle + 3 busy + 1 release + 1 update.
    rd_seen = 1'b0;
    do_access(1'b0, 3'b010, 32'h40, 32'h0, st);
    check("cold LW stalls", 32'(st), 32'd6);
    check("cold LW fetch addr", 32'(rd_addr), 32'h4);

    // Reset while a fetch is outstanding.
    @(posedge clk); #1;
    addr = 32'h300; mem_read = 4'b1010;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (!main_read && wait_cnt < 50);
    check("abort saw main_read", 32'(main_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 4'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort main_read", 32'(main_read), 32'd0);
    check("abort busywait",  32'(busywait),  32'd0);
    do_access(1'b0, 3'b010, 32'h300, 32'h0, st);
    check("after reset misses", 32'(st > 0), 32'd1);

    // Extension on hit.
    do_access(1'b1, 3'b010, 32'h40, 32'h0000_80F0, st);
    for (int i = 0; i < 5; i++) begin
      if (lf[i] != 3'b010) begin
        do_access(1'b0, lf[i], 32'h40, 32'h0, st);
        check("ext load stalls", 32'(st), 32'd0);
      end
    end

    // Store hit merge.
    do_access(1'b1, 3'b010, 32'h40, 32'h1122_3344, st);
    check("SW hit stalls", 32'(st), 32'd0);
    do_access(1'b1, 3'b000, 32'h41, 32'h0000_00AA, st);
    check("SB hit stalls", 32'(st), 32'd0);
    do_access(1'b0, 3'b010, 32'h40, 32'h0, st);
    check("merge LW stalls", 32'(st), 32'd0);

    // Dirty eviction.
    wb_seen = 1'b0; rd_seen = 1'b0;
    do_access(1'b0, 3'b010, 32'hC0, 32'h0, st);
    check("evict wb seen",  32'(wb_seen), 32'd1);
    check("evict wb addr",  32'(wb_addr), 32'h4);
    check("evict wb word0", wb_word0,     32'h1122_AA44);
    check("evict fetch addr", 32'(rd_addr), 32'hC);

    // Store miss allocate.
    do_access(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, st);
    check("SW miss stalls", 32'(st > 0), 32'd1);
    t0 = traffic;
    do_access(1'b0, 3'b010, 32'h200, 32'h0, st);
    check("alloc LW stalls", 32'(st), 32'd0);
    check("alloc no traffic", 32'(traffic - t0), 32'd0);

    // Randomised traffic with random memory latency.
    fixed_lat = -1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4)
        do_access(1'b1, 3'($urandom_range(0, 2)), 32'($urandom_range(0, 4095)), $urandom, st);
      else
        do_access(1'b0, lf[$urandom_range(0, 4)], 32'($urandom_range(0, 4095)), 32'h0, st);
    end

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
